// File: rtl/ram_pkg.sv
// ram_pkg
//   Constants and types shared by the single-port RAM, its FIFO controller
//   and their benches.
//   RAM_DATA_W : default data width (RAM Din/Dout)
//   RAM_ADDR_W : default address width
//   RAM_DEPTH  : number of RAM words for the default address width
//   state_t    : controller state (S_CLEAR zero-fill, S_RUN normal traffic)
package ram_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller in front of a single-port RAM with a registered read
//   port. Turns a valid/ready push stream and a request-based pop stream
//   into RAM write/read cycles and optionally zero-fills the RAM after reset.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_CLEAR | writing zero to every RAM word, one per cycle, from address 0
//   S_RUN   | servicing pops and pushes, one RAM access per cycle, pop first
//
//   Ports
//   clk, rst             : clock, synchronous active-high reset
//   push_valid/push_data : producer offer; push_ready accepts it
//   pop_req              : consumer request for one word
//   pop_valid/pop_data   : dequeued word, one cycle after the accepted request
//   full, empty, count   : occupancy status
//   busy                 : zero-fill in progress
//   ram_din/addr/en/we   : RAM command port
//   ram_dout             : RAM read data (registered inside the RAM)
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W       = RAM_DATA_W,
  parameter int ADDR_W       = RAM_ADDR_W,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(1 << ADDR_W);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W:0]   cnt;
  logic              pop_valid_q;
  logic              run;
  logic              clearing;
  logic              pop_go;
  logic              push_go;

  // Reset is synchronous, but the RAM command and handshake outputs are
  // also forced idle while rst is high so nothing reaches the RAM (and no
  // stale read returns) during the reset cycle itself.
  assign run      = ~rst & (state == S_RUN);
  assign clearing = ~rst & (state == S_CLEAR);

  assign empty      = (cnt == '0);
  assign full       = (cnt == DEPTH_C);
  assign count      = cnt;
  assign pop_go     = run & pop_req & ~empty;
  assign push_ready = run & ~full & ~pop_go;
  assign push_go    = push_valid & push_ready;

  assign busy      = rst ? CLEAR_ON_RST : (state == S_CLEAR);
  assign pop_valid = pop_valid_q & ~rst;
  assign pop_data  = ram_dout;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (clearing) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_addr;
    end else if (pop_go) begin
      ram_en   = 1'b1;
      ram_addr = rd_ptr;
    end else if (push_go) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_ptr;
      ram_din  = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR_ON_RST ? S_CLEAR : S_RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      clr_addr    <= '0;
      cnt         <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_go;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (&clr_addr) state <= S_RUN;
        end
        S_RUN: begin
          // pop and push are mutually exclusive by construction of push_ready
          if (pop_go) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt    <= cnt - (ADDR_W + 1)'(1);
          end else if (push_go) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            cnt    <= cnt + (ADDR_W + 1)'(1);
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
